ecc_sed_enc_arbiter: RTL and testbench



---
 rtl/ecc_sed_pkg.sv | 21 ++
 rtl/ecc_rr_arbiter.sv | 32 +++
 rtl/ecc_sed_enc_arbiter.sv | 119 +++++++++++
 tb/tb_ecc_sed_enc_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sed_pkg.sv
// Shared constants and helpers for the single-error-detect encoder path.
// sed_parity is also used by the encoder bench so both agree on even parity.
package ecc_sed_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int CW_W_DEF   = DATA_W_DEF + 1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic sed_parity(input logic [DATA_W_DEF-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ecc_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above rr_ptr_i,
// wrapping around; returns one-hot grant, its index and an any-request flag.
module ecc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_vld_o
);

    logic found;
    int   idx;

    always_comb begin
        found     = 1'b0;
        idx       = 0;
        gnt_idx_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = ID_W'(idx);
            end
        end
        gnt_vld_o = found;
        gnt_o     = found ? (NUM_REQ'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/ecc_sed_enc_arbiter.sv
// Round-robin share of one combinational SED encoder, with a single backpressured output register.
// Define ECC_SED_ARB_CHECK_EN to add the sticky par_err encoder self-check.
module ecc_sed_enc_arbiter
    import ecc_sed_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      enc_data_valid,
    output logic [DATA_W-1:0]         enc_data,
    input  logic                      enc_valid,
    input  logic [DATA_W:0]           enc_codeword,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W:0]           out_codeword,
    output logic [ID_W-1:0]           out_id,
    output logic [15:0]               accept_cnt
`ifdef ECC_SED_ARB_CHECK_EN
    ,
    output logic                      par_err
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_vld;
    logic               can_load;
    logic               accept;

    buf_state_e         state_q, state_d;
    logic [DATA_W:0]    cw_q, cw_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [15:0]        cnt_q, cnt_d;

    ecc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .rr_ptr_i  (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // A missing enc_valid or a reset cycle suppresses the handshake entirely.
    always_comb begin
        can_load       = (state_q == BUF_EMPTY) | out_ready;
        enc_data_valid = gnt_vld & can_load;
        enc_data       = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        accept         = enc_data_valid & enc_valid & ~rst;
        req_ready      = accept ? gnt : '0;
    end

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = BUF_FULL;
            cw_d    = enc_codeword;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_d   = cnt_q + 16'd1;
        end else if ((state_q == BUF_FULL) && out_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            cw_q    <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = (state_q == BUF_FULL);
    assign out_codeword = cw_q;
    assign out_id       = id_q;
    assign accept_cnt   = cnt_q;

`ifdef ECC_SED_ARB_CHECK_EN
    logic par_err_q;
    logic cw_bad;

    // Catches both a wrong parity bit and data bits corrupted inside the encoder.
    assign cw_bad = ((^enc_codeword[DATA_W-1:0]) != enc_codeword[DATA_W])
                  | (enc_codeword[DATA_W-1:0] != enc_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (accept && cw_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Scoreboard bench for ecc_sed_enc_arbiter: a queue-based reference of the arbitration
// rules predicts each accepted word; a separate monitor compares on every output drain.
module tb_ecc_sed_enc_arbiter;
    import ecc_sed_pkg::*;

    localparam int N  = 4;
    localparam int DW = DATA_W_DEF;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW:0]   cw;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            enc_data_valid;
    logic [DW-1:0]   enc_data;
    logic            enc_valid;
    logic [DW:0]     enc_codeword;
    logic            out_valid;
    logic            out_ready;
    logic [DW:0]     out_codeword;
    logic [1:0]      out_id;
    logic [15:0]     accept_cnt;
`ifdef ECC_SED_ARB_CHECK_EN
    logic            par_err;
`endif

    logic            enc_fault;
    logic            par_flip;

    always #5 clk = ~clk;

    // Stand-in for the shared encoder, with fault injection knobs.
    assign enc_valid    = enc_data_valid & ~enc_fault;
    assign enc_codeword = {sed_parity(enc_data) ^ par_flip, enc_data};

    ecc_sed_enc_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .enc_data_valid (enc_data_valid),
        .enc_data       (enc_data),
        .enc_valid      (enc_valid),
        .enc_codeword   (enc_codeword),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_codeword   (out_codeword),
        .out_id         (out_id),
        .accept_cnt     (accept_cnt)
`ifdef ECC_SED_ARB_CHECK_EN
        ,
        .par_err        (par_err)
`endif
    );

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];

    bit          rv[N];
    logic [DW-1:0] rd[N];
    bit          m_full;
    int          m_ptr;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at posedge+1, evaluate the reference at posedge+2.
    task automatic step(input bit r, input bit rdy, input int p_new, input bit fault, input bit flip);
        int   g;
        int   idx;
        bit   acc;
        logic [N-1:0] exp_rdy;
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        out_ready = rdy;
        enc_fault = fault;
        par_flip  = flip;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rv[i];
            req_data[i*DW +: DW] = rd[i];
        end
        #1;
        if (r) begin
            chk("ready_in_reset", 32'(req_ready), 32'h0);
            m_full = 1'b0;
            m_ptr  = 0;
            m_cnt  = '0;
            exp_q.delete();
            return;
        end
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("accept_cnt", 32'(accept_cnt), 32'(m_cnt));
        if (m_full && exp_q.size() > 0) begin
            chk("held_codeword", 32'(out_codeword), 32'(exp_q[0].cw));
            chk("held_id", 32'(out_id), 32'(exp_q[0].id));
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && rv[idx]) g = idx;
        end
        acc     = (g >= 0) && (!m_full || rdy) && !fault;
        exp_rdy = acc ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (acc) begin
            e.id  = 2'(g);
            e.cw  = {sed_parity(rd[g]) ^ flip, rd[g]};
            exp_q.push_back(e);
            m_ptr  = (g + 1) % N;
            m_cnt  = m_cnt + 16'd1;
            m_full = 1'b1;
            rv[g]  = 1'b0;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!rv[i] && ($urandom_range(99) < p_new)) begin
                rv[i] = 1'b1;
                rd[i] = DW'($urandom);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_output: got id=%0d cw=0x%0h expected none", out_id, out_codeword);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", 32'(out_id), 32'(e.id));
                    chk("out_codeword", 32'(out_codeword), 32'(e.cw));
                end
            end
        end
    end

    initial begin : stim
        int guard;
        rst       = 1'b1;
        out_ready = 1'b0;
        enc_fault = 1'b0;
        par_flip  = 1'b0;
        req_valid = '1;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            rd[i] = DW'(i + 1);
        end

        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        step(0, 1, 0, 0, 0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_accept_cnt", 32'(accept_cnt), 32'h0);

        rv[2] = 1'b1;
        rd[2] = 12'h0A5;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("single_cw_even", 32'(out_codeword), 32'h00A5);
        chk("single_id", 32'(out_id), 32'h2);
        rv[2] = 1'b1;
        rd[2] = 12'h0A4;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("single_cw_odd", 32'(out_codeword), 32'h10A4);
        step(0, 1, 0, 0, 0);

        step(1, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            rd[i] = DW'($urandom);
        end
        for (int c = 0; c < 12; c++) step(0, 1, 100, 0, 0);

        for (int c = 0; c < 5; c++) step(0, 0, 100, 0, 0);
        for (int c = 0; c < 4; c++) step(0, 1, 100, 0, 0);

        step(0, 1, 100, 1, 0);
        step(0, 1, 100, 1, 0);
        for (int c = 0; c < 4; c++) step(0, 1, 100, 0, 0);

        for (int c = 0; c < 400; c++)
            step(0, $urandom_range(3) != 0, 50, $urandom_range(15) == 0, 0);

        step(0, 0, 100, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int c = 0; c < 20; c++) step(0, $urandom_range(1) != 0, 60, 0, 0);

`ifdef ECC_SED_ARB_CHECK_EN
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        step(0, 1, 0, 0, 0);
        chk("par_err_clear", 32'(par_err), 32'h0);
        rv[0] = 1'b1;
        rd[0] = 12'h001;
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("par_err_set", 32'(par_err), 32'h1);
        for (int c = 0; c < 4; c++) step(0, 1, 40, 0, 0);
        chk("par_err_sticky", 32'(par_err), 32'h1);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("par_err_rst", 32'(par_err), 32'h0);
`endif

        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(0, 1, 100, 0, 0);
            guard++;
        end
        chk("wrap_reached", 32'(m_cnt), 32'hFFFF);
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        rv[1] = 1'b1;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("cnt_wrap", 32'(accept_cnt), 32'h0);

        for (int c = 0; c < 3; c++) step(0, 1, 0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
